// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the OTTER multicycle control unit.
//   - state_t      : sequencer states (FETCH, EXEC, WRITEBACK, TRAP)
//   - OPC_*        : RV32I major opcodes (instruction bits [6:0])
//   - RF_* / SRCA_* / SRCB_* : select encodings for the shared 4:1 muxes
package otter_pkg;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        EXEC      = 2'd1,
        WRITEBACK = 2'd2,
        TRAP      = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Register-file writeback mux
    localparam logic [1:0] RF_PC4 = 2'b00;
    localparam logic [1:0] RF_CSR = 2'b01;
    localparam logic [1:0] RF_MEM = 2'b10;
    localparam logic [1:0] RF_ALU = 2'b11;

    // ALU operand A mux (encoding 11 is unused and never driven)
    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_UIMM = 2'b01;
    localparam logic [1:0] SRCA_NRS1 = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IIMM = 2'b01;
    localparam logic [1:0] SRCB_SIMM = 2'b10;
    localparam logic [1:0] SRCB_PC   = 2'b11;

endpackage

// File: rtl/otter_sel_decode.sv
// otter_sel_decode: combinational decode of an instruction's opcode/func3
// into the mux selects used while it executes.
// Ports:
//   i_opcode    in  7  instruction bits [6:0]
//   i_func3     in  3  instruction bits [14:12]
//   o_rf_sel    out 2  writeback mux select for the EXEC cycle
//   o_alu_srca  out 2  ALU operand A select
//   o_alu_srcb  out 2  ALU operand B select
//   o_illegal   out 1  opcode is not a recognised RV32I major opcode
module otter_sel_decode
    import otter_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_func3,
    output logic [1:0] o_rf_sel,
    output logic [1:0] o_alu_srca,
    output logic [1:0] o_alu_srcb,
    output logic       o_illegal
);

    always_comb begin
        o_rf_sel   = RF_PC4;
        o_alu_srca = SRCA_RS1;
        o_alu_srcb = SRCB_RS2;
        o_illegal  = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                o_rf_sel = RF_ALU;
            end
            OPC_OP_IMM: begin
                o_rf_sel   = RF_ALU;
                o_alu_srcb = SRCB_IIMM;
            end
            OPC_LUI: begin
                o_rf_sel   = RF_ALU;
                o_alu_srca = SRCA_UIMM;
            end
            OPC_AUIPC: begin
                o_rf_sel   = RF_ALU;
                o_alu_srca = SRCA_UIMM;
                o_alu_srcb = SRCB_PC;
            end
            OPC_JAL, OPC_JALR: begin
                o_rf_sel = RF_PC4;
            end
            OPC_BRANCH: begin
                o_rf_sel = RF_PC4;
            end
            OPC_STORE: begin
                o_alu_srcb = SRCB_SIMM;
            end
            // Address is rs1 + I-imm; the writeback select comes later.
            OPC_LOAD: begin
                o_alu_srcb = SRCB_IIMM;
            end
            // CSR ops write the old CSR value to rd; mret (func3=000) writes nothing.
            OPC_SYSTEM: begin
                if (i_func3 != 3'b000) begin
                    o_rf_sel = RF_CSR;
                end
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle control sequencer for the OTTER RV32I core.
// Steps each instruction through FETCH -> EXEC [-> WRITEBACK] [-> TRAP].
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   OPCODE, FUNC3            current instruction fields
//   MEM_VALID                memory completed fetch / data read
//   INTR, MIE                interrupt request (level) and enable
//   PC_WRITE .. ILLEGAL      datapath strobes (combinational)
//   RF_SEL, ALU_SRCA/SRCB    mux selects (combinational)
//   INSTRET                  registered retired-instruction counter
//   DBG_STATE                current sequencer state, for observation only
// Handshake: MEM_VALID is sampled only in FETCH and WRITEBACK; a low MEM_VALID
// holds the sequencer (and the read enable) in place for another cycle, and the
// cycle it is high completes the access. It is don't-care in EXEC and TRAP.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNC3,
    input  logic             MEM_VALID,
    input  logic             INTR,
    input  logic             MIE,
    output logic             PC_WRITE,
    output logic             REG_WRITE,
    output logic             MEM_RDEN1,
    output logic             MEM_RDEN2,
    output logic             MEM_WE2,
    output logic             CSR_WE,
    output logic             INT_TAKEN,
    output logic             MRET_EXEC,
    output logic             ILLEGAL,
    output logic [1:0]       RF_SEL,
    output logic [1:0]       ALU_SRCA,
    output logic [1:0]       ALU_SRCB,
    output logic [CNT_W-1:0] INSTRET,
    output logic [1:0]       DBG_STATE
);

    state_t           r_state;
    logic [CNT_W-1:0] r_instret;

    logic [1:0] w_dec_rf_sel;
    logic [1:0] w_dec_srca;
    logic [1:0] w_dec_srcb;
    logic       w_dec_illegal;
    logic       w_is_load;
    logic       w_is_system;
    logic       w_writes_rd;
    logic       w_instr_end;
    logic       w_take_trap;

    otter_sel_decode u_sel_decode (
        .i_opcode   (OPCODE),
        .i_func3    (FUNC3),
        .o_rf_sel   (w_dec_rf_sel),
        .o_alu_srca (w_dec_srca),
        .o_alu_srcb (w_dec_srcb),
        .o_illegal  (w_dec_illegal)
    );

    assign w_is_load   = (OPCODE == OPC_LOAD);
    assign w_is_system = (OPCODE == OPC_SYSTEM);
    assign w_writes_rd = (OPCODE == OPC_OP)  || (OPCODE == OPC_OP_IMM) ||
                         (OPCODE == OPC_LUI) || (OPCODE == OPC_AUIPC)  ||
                         (OPCODE == OPC_JAL) || (OPCODE == OPC_JALR)   ||
                         (w_is_system && (FUNC3 != 3'b000));

    // An instruction ends on the cycle it updates the PC: EXEC for everything
    // but loads, WRITEBACK once the load data has arrived.
    assign w_instr_end = ((r_state == EXEC) && !w_is_load) ||
                         ((r_state == WRITEBACK) && MEM_VALID);
    assign w_take_trap = INTR && MIE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= FETCH;
            r_instret <= '0;
        end else begin
            if (w_instr_end) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            case (r_state)
                FETCH: begin
                    if (MEM_VALID) begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_is_load) begin
                        r_state <= WRITEBACK;
                    end else if (w_take_trap) begin
                        r_state <= TRAP;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                WRITEBACK: begin
                    if (MEM_VALID) begin
                        r_state <= w_take_trap ? TRAP : FETCH;
                    end
                end
                TRAP: begin
                    r_state <= FETCH;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // Strobes/selects are combinational; reset forces them all low even though
    // the state register already reads FETCH during reset.
    always_comb begin
        PC_WRITE  = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        ILLEGAL   = 1'b0;
        RF_SEL    = RF_PC4;
        ALU_SRCA  = SRCA_RS1;
        ALU_SRCB  = SRCB_RS2;
        if (RST_N) begin
            case (r_state)
                FETCH: begin
                    MEM_RDEN1 = 1'b1;
                end
                EXEC: begin
                    RF_SEL    = w_dec_rf_sel;
                    ALU_SRCA  = w_dec_srca;
                    ALU_SRCB  = w_dec_srcb;
                    ILLEGAL   = w_dec_illegal;
                    PC_WRITE  = !w_is_load;
                    REG_WRITE = w_writes_rd;
                    MEM_RDEN2 = w_is_load;
                    MEM_WE2   = (OPCODE == OPC_STORE);
                    CSR_WE    = w_is_system && (FUNC3 != 3'b000);
                    MRET_EXEC = w_is_system && (FUNC3 == 3'b000);
                end
                WRITEBACK: begin
                    // Keep the read and its address stable until data returns.
                    MEM_RDEN2 = 1'b1;
                    ALU_SRCB  = SRCB_IIMM;
                    if (MEM_VALID) begin
                        REG_WRITE = 1'b1;
                        PC_WRITE  = 1'b1;
                        RF_SEL    = RF_MEM;
                    end
                end
                TRAP: begin
                    INT_TAKEN = 1'b1;
                    PC_WRITE  = 1'b1;
                end
                default: begin
                    PC_WRITE = 1'b0;
                end
            endcase
        end
    end

    assign INSTRET   = r_instret;
    assign DBG_STATE = r_state;

endmodule
